// File: rtl/gray_frame_diff_if.sv
// Pixel stream, frame-buffer FIFO and binary motion stream bundle
// for the gray_frame_diff stage.
interface gray_frame_diff_if;
  logic       gray_vsync;
  logic       gray_href;
  logic       gray_valid;
  logic [7:0] gray_data;
  logic [7:0] prev_data;
  logic       prev_empty;
  logic       prev_rd_en;
  logic       cur_full;
  logic       cur_wr_en;
  logic [7:0] cur_wr_data;
  logic       bin_vsync;
  logic       bin_href;
  logic       bin_valid;
  logic [7:0] bin_data;

  modport master (
    output gray_vsync, gray_href, gray_valid, gray_data,
    output prev_data, prev_empty, cur_full,
    input  prev_rd_en, cur_wr_en, cur_wr_data,
    input  bin_vsync, bin_href, bin_valid, bin_data
  );

  modport slave (
    input  gray_vsync, gray_href, gray_valid, gray_data,
    input  prev_data, prev_empty, cur_full,
    output prev_rd_en, cur_wr_en, cur_wr_data,
    output bin_vsync, bin_href, bin_valid, bin_data
  );
endinterface

// File: rtl/gray_frame_diff.sv
// Frame-to-frame grayscale difference with threshold, binary
// motion stream and per-frame motion-pixel count.
module gray_frame_diff #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  gray_frame_diff_if.slave bus,
  input  logic [7:0]       thresh,
  output logic [CNT_W-1:0] motion_cnt,
  output logic             frame_done,
  output logic             underflow_err,
  output logic             overflow_err
);

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    FIRST     = 2'd1,
    DIFF      = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_n;
  logic             vs_d1, vs_rise;
  logic [7:0]       thr_l;
  logic [8:0]       sub;
  logic [7:0]       abs_d;
  logic             cmp_now;
  logic [7:0]       diff_r;
  logic             cmp_ok;
  logic             vs1, href1, valid1;
  logic             bv_d1, bv_rise, hit;
  logic [CNT_W-1:0] acc;

  assign vs_rise = bus.gray_vsync & ~vs_d1;

  // Frame boundary detect and per-frame threshold latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d1 <= 1'b0;
      thr_l <= 8'h00;
    end else begin
      vs_d1 <= bus.gray_vsync;
      if (vs_rise) thr_l <= thresh;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_SYNC;
    else        state <= state_n;
  end

  // Next state: one boundary to start storing, one more to compare
  always_comb begin
    state_n = state;
    unique case (state)
      WAIT_SYNC: if (vs_rise) state_n = FIRST;
      FIRST:     if (vs_rise) state_n = DIFF;
      DIFF:      state_n = DIFF;
      default:   state_n = WAIT_SYNC;
    endcase
  end

  // FIFO strobes and absolute difference of current vs previous
  always_comb begin
    bus.cur_wr_en   = bus.gray_valid & ~bus.cur_full
                    & (state != WAIT_SYNC);
    bus.cur_wr_data = bus.gray_data;
    cmp_now         = bus.gray_valid & ~bus.prev_empty
                    & (state == DIFF);
    bus.prev_rd_en  = cmp_now;
    sub   = {1'b0, bus.gray_data} - {1'b0, bus.prev_data};
    abs_d = sub[8] ? (~sub[7:0] + 8'd1) : sub[7:0];
  end

  // Stage 1: register difference, compare-enable and syncs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_r <= 8'h00;
      cmp_ok <= 1'b0;
      vs1    <= 1'b0;
      href1  <= 1'b0;
      valid1 <= 1'b0;
    end else begin
      diff_r <= cmp_now ? abs_d : 8'h00;
      cmp_ok <= cmp_now;
      vs1    <= bus.gray_vsync;
      href1  <= bus.gray_href;
      valid1 <= bus.gray_valid;
    end
  end

  // Stage 2: strict threshold compare onto the binary stream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.bin_vsync <= 1'b0;
      bus.bin_href  <= 1'b0;
      bus.bin_valid <= 1'b0;
      bus.bin_data  <= 8'h00;
    end else begin
      bus.bin_vsync <= vs1;
      bus.bin_href  <= href1;
      bus.bin_valid <= valid1;
      bus.bin_data  <= (valid1 & cmp_ok & (diff_r > thr_l))
                     ? 8'hFF : 8'h00;
    end
  end

  assign bv_rise = bus.bin_vsync & ~bv_d1;
  assign hit     = bus.bin_valid & (bus.bin_data == 8'hFF);

  // Saturating motion accumulator, published at each output frame edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bv_d1      <= 1'b0;
      acc        <= '0;
      motion_cnt <= '0;
      frame_done <= 1'b0;
    end else begin
      bv_d1      <= bus.bin_vsync;
      frame_done <= bv_rise;
      if (bv_rise) begin
        motion_cnt <= acc;
        acc        <= hit ? CNT_W'(1) : '0;
      end else if (hit && acc != CNT_MAX) begin
        acc <= acc + CNT_W'(1);
      end
    end
  end

  // Sticky FIFO error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow_err <= 1'b0;
      overflow_err  <= 1'b0;
    end else begin
      if (bus.gray_valid & bus.prev_empty & (state == DIFF))
        underflow_err <= 1'b1;
      if (bus.gray_valid & bus.cur_full & (state != WAIT_SYNC))
        overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gray_frame_diff.sv
// Scoreboard bench for gray_frame_diff: directed frames, monitor
// checks the binary stream, latency and per-frame counts.
module tb_gray_frame_diff;

  typedef struct {
    int         cyc;
    logic [7:0] val;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [7:0]  thresh;
  logic [19:0] motion_cnt;
  logic        frame_done;
  logic        underflow_err;
  logic        overflow_err;

  gray_frame_diff_if bus();

  gray_frame_diff #(.CNT_W(20)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .thresh        (thresh),
    .motion_cnt    (motion_cnt),
    .frame_done    (frame_done),
    .underflow_err (underflow_err),
    .overflow_err  (overflow_err)
  );

  int   tests;
  int   fails;
  int   cyc;
  exp_t bq[$];
  int   cq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter for latency checks
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name,
                                logic [31:0] act,
                                logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: pop expectations whenever the DUT presents output
  always @(negedge clk) begin
    exp_t e;
    int   c;
    if (rst_n) begin
      if (bus.bin_valid) begin
        if (bq.size() == 0) begin
          check("bin_unexpected", 1, 0);
        end else begin
          e = bq.pop_front();
          check("bin_data", bus.bin_data, e.val);
          check("bin_latency", cyc, e.cyc);
        end
      end else if (bus.bin_data != 8'h00) begin
        check("bin_idle_zero", bus.bin_data, 0);
      end
      if (frame_done) begin
        if (cq.size() == 0) begin
          check("frame_done_unexpected", 1, 0);
        end else begin
          c = cq.pop_front();
          check("motion_cnt", motion_cnt, c);
        end
      end
    end
  end

  task automatic drive(input logic vs, input logic hr,
                       input logic v, input logic [7:0] g,
                       input logic [7:0] p, input logic pe,
                       input logic cf);
    @(posedge clk);
    #1;
    bus.gray_vsync = vs;
    bus.gray_href  = hr;
    bus.gray_valid = v;
    bus.gray_data  = g;
    bus.prev_data  = p;
    bus.prev_empty = pe;
    bus.cur_full   = cf;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 8'h00, 8'h00, 0, 0);
  endtask

  task automatic pix(input logic [7:0] g, input logic [7:0] p,
                     input logic pe, input logic cf,
                     input logic [7:0] eb, input logic ewr,
                     input logic erd);
    drive(0, 1, 1, g, p, pe, cf);
    #1;
    check("cur_wr_en", bus.cur_wr_en, ewr);
    check("prev_rd_en", bus.prev_rd_en, erd);
    if (ewr) check("cur_wr_data", bus.cur_wr_data, g);
    bq.push_back('{cyc + 2, eb});
  endtask

  task automatic vs_pulse(input int ecnt);
    idle(3);
    cq.push_back(ecnt);
    repeat (2) drive(1, 0, 0, 8'h00, 8'h00, 0, 0);
    idle(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tests = 0;
    fails = 0;
    cyc   = 0;
    rst_n = 1'b0;
    thresh = 8'h0F;
    bus.gray_vsync = 0;
    bus.gray_href  = 0;
    bus.gray_valid = 0;
    bus.gray_data  = 8'h00;
    bus.prev_data  = 8'h00;
    bus.prev_empty = 0;
    bus.cur_full   = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_bin_valid", bus.bin_valid, 0);
    check("rst_bin_data", bus.bin_data, 0);
    check("rst_motion_cnt", motion_cnt, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_underflow", underflow_err, 0);
    check("rst_overflow", overflow_err, 0);
    rst_n = 1'b1;

    vs_pulse(0);
    repeat (8) pix(8'h40, 8'h40, 0, 0, 8'h00, 1, 0);
    vs_pulse(0);

    pix(8'h40, 8'h40, 0, 0, 8'h00, 1, 1);
    pix(8'h50, 8'h40, 0, 0, 8'hFF, 1, 1);
    pix(8'h30, 8'h40, 0, 0, 8'hFF, 1, 1);
    pix(8'h41, 8'h40, 0, 0, 8'h00, 1, 1);
    thresh = 8'h10;
    vs_pulse(2);
    check("no_underflow_yet", underflow_err, 0);
    check("no_overflow_yet", overflow_err, 0);

    pix(8'h50, 8'h40, 0, 0, 8'h00, 1, 1);
    pix(8'h51, 8'h40, 0, 0, 8'hFF, 1, 1);
    pix(8'h30, 8'h40, 0, 0, 8'h00, 1, 1);
    pix(8'h00, 8'hFF, 0, 0, 8'hFF, 1, 1);
    pix(8'hFF, 8'h00, 0, 0, 8'hFF, 1, 1);
    repeat (3) pix(8'hFF, 8'h00, 1, 0, 8'h00, 1, 0);
    idle(1);
    check("underflow_set", underflow_err, 1);
    check("overflow_clear", overflow_err, 0);
    repeat (2) pix(8'h80, 8'h00, 0, 1, 8'hFF, 0, 1);
    idle(1);
    check("overflow_set", overflow_err, 1);
    thresh = 8'h08;
    vs_pulse(5);

    pix(8'h20, 8'h10, 0, 0, 8'hFF, 1, 1);
    thresh = 8'h40;
    pix(8'h30, 8'h00, 0, 0, 8'hFF, 1, 1);
    pix(8'h00, 8'h09, 0, 0, 8'hFF, 1, 1);
    vs_pulse(3);

    pix(8'h30, 8'h00, 0, 0, 8'h00, 1, 1);
    pix(8'h41, 8'h00, 0, 0, 8'hFF, 1, 1);
    check("underflow_sticky", underflow_err, 1);
    check("overflow_sticky", overflow_err, 1);

    pix(8'hFF, 8'h00, 0, 0, 8'hFF, 1, 1);
    pix(8'hFF, 8'h00, 0, 0, 8'hFF, 1, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_bin_valid", bus.bin_valid, 0);
    check("mid_rst_bin_data", bus.bin_data, 0);
    check("mid_rst_motion_cnt", motion_cnt, 0);
    check("mid_rst_underflow", underflow_err, 0);
    check("mid_rst_overflow", overflow_err, 0);
    check("mid_rst_wr_en", bus.cur_wr_en, 0);
    check("mid_rst_rd_en", bus.prev_rd_en, 0);
    bq.delete();
    cq.delete();
    bus.gray_href  = 0;
    bus.gray_valid = 0;
    @(negedge clk);
    rst_n = 1'b1;

    pix(8'hFF, 8'h00, 0, 0, 8'h00, 0, 0);
    vs_pulse(0);
    pix(8'hFF, 8'h00, 0, 0, 8'h00, 1, 0);
    vs_pulse(0);
    pix(8'hFF, 8'h00, 0, 0, 8'hFF, 1, 1);
    vs_pulse(1);

    idle(6);
    check("bin_queue_drained", bq.size(), 0);
    check("cnt_queue_drained", cq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
